// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
//
// Run/step/break controller for the single-cycle CPU core. The host issues
// RUN, STEP N, STOP and CLEAR commands. The block drives the core's global_en
// so that the core executes freely, executes a fixed number of instructions,
// or is held. It watches the fetch PC and the fetched instruction to stop on a
// PC breakpoint or on the halt instruction. It also counts every cycle in which
// the core was enabled.
//
// Parameters
//   HALT_INST  instruction encoding that ends execution
//   STEP_W     width of the step-count argument and remaining-step counter
//   CNT_W      width of the executed-instruction counter
//
// Ports
//   clk          in   clock
//   rst          in   synchronous, active-high reset
//   cmd_valid    in   command strobe, one cycle per command
//   cmd_op       in   00 RUN, 01 STEP, 10 STOP, 11 CLEAR
//   cmd_arg      in   step count for STEP (0 is treated as 1)
//   cmd_err      out  registered one-cycle pulse for an illegal command
//   bp_en        in   breakpoint enable
//   bp_pc        in   breakpoint address
//   fetch_pc     in   current PC of the core (imem_raddr)
//   fetch_inst   in   instruction at fetch_pc (imem_rdata)
//   global_en    out  core execute enable (combinational)
//   state        out  0 IDLE, 1 RUN, 2 STEP, 3 PAUSED, 4 HALTED
//   stop_reason  out  0 none, 1 user stop, 2 step done, 3 breakpoint, 4 halt
//   inst_cnt     out  number of cycles with global_en=1 (wraps)
//   steps_left   out  remaining steps (0 outside STEP)
// -----------------------------------------------------------------------------
module cpu_run_ctrl #(
    parameter logic [31:0] HALT_INST = 32'h8000_0000,
    parameter int          STEP_W    = 16,
    parameter int          CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_arg,
    output logic              cmd_err,
    input  logic              bp_en,
    input  logic [31:0]       bp_pc,
    input  logic [31:0]       fetch_pc,
    input  logic [31:0]       fetch_inst,
    output logic              global_en,
    output logic [2:0]        state,
    output logic [2:0]        stop_reason,
    output logic [CNT_W-1:0]  inst_cnt,
    output logic [STEP_W-1:0] steps_left
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_PAUSED = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam logic [1:0] OP_RUN   = 2'b00;
    localparam logic [1:0] OP_STEP  = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [2:0] R_NONE  = 3'd0;
    localparam logic [2:0] R_USER  = 3'd1;
    localparam logic [2:0] R_STEP  = 3'd2;
    localparam logic [2:0] R_BREAK = 3'd3;
    localparam logic [2:0] R_HALT  = 3'd4;

    state_t            state_q,      state_d;
    logic [2:0]        reason_q,     reason_d;
    logic [CNT_W-1:0]  inst_cnt_q,   inst_cnt_d;
    logic [STEP_W-1:0] steps_left_q, steps_left_d;
    logic              cmd_err_q,    cmd_err_d;
    logic              skip_bp_q,    skip_bp_d;

    logic active;
    logic stop_cmd;
    logic bp_hit;
    logic halt_hit;

    // Event decode against the current fetch.
    assign active   = (state_q == S_RUN) || (state_q == S_STEP);
    assign stop_cmd = cmd_valid && (cmd_op == OP_STOP) && active;
    // skip_bp lets a resume from a breakpoint PC execute that instruction once.
    assign bp_hit   = bp_en && (fetch_pc == bp_pc) && !skip_bp_q;
    assign halt_hit = (fetch_inst == HALT_INST);

    // A stop or breakpoint gates the current instruction; halt does not, so the
    // halt instruction itself executes and commits. rst forces the core off in
    // the same cycle rather than waiting for the state register to clear.
    assign global_en = active && !stop_cmd && !bp_hit && !rst;

    // Next-state and command handling.
    always_comb begin
        state_d      = state_q;
        reason_d     = reason_q;
        inst_cnt_d   = inst_cnt_q;
        steps_left_d = steps_left_q;
        cmd_err_d    = 1'b0;
        skip_bp_d    = skip_bp_q;

        if (global_en) begin
            inst_cnt_d = inst_cnt_q + CNT_W'(1);
            skip_bp_d  = 1'b0;
        end

        case (state_q)
            S_RUN, S_STEP: begin
                // Only STOP is meaningful while the core is running.
                if (cmd_valid && (cmd_op != OP_STOP)) begin
                    cmd_err_d = 1'b1;
                end

                if (stop_cmd) begin
                    state_d      = S_PAUSED;
                    reason_d     = R_USER;
                    steps_left_d = '0;
                end else if (bp_hit) begin
                    state_d      = S_PAUSED;
                    reason_d     = R_BREAK;
                    steps_left_d = '0;
                end else if (halt_hit) begin
                    state_d      = S_HALTED;
                    reason_d     = R_HALT;
                    steps_left_d = '0;
                end else if (state_q == S_STEP) begin
                    if (steps_left_q == STEP_W'(1)) begin
                        state_d      = S_PAUSED;
                        reason_d     = R_STEP;
                        steps_left_d = '0;
                    end else begin
                        steps_left_d = steps_left_q - STEP_W'(1);
                    end
                end
            end

            S_IDLE, S_PAUSED: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_RUN: begin
                            state_d   = S_RUN;
                            reason_d  = R_NONE;
                            skip_bp_d = 1'b1;
                        end
                        OP_STEP: begin
                            state_d      = S_STEP;
                            reason_d     = R_NONE;
                            skip_bp_d    = 1'b1;
                            steps_left_d = (cmd_arg == '0) ? STEP_W'(1) : cmd_arg;
                        end
                        OP_CLEAR: begin
                            state_d    = S_IDLE;
                            reason_d   = R_NONE;
                            inst_cnt_d = '0;
                        end
                        default: begin
                            // STOP with nothing running.
                            cmd_err_d = 1'b1;
                        end
                    endcase
                end
            end

            S_HALTED: begin
                // Only CLEAR leaves HALTED; restarting the core PC is up to rst.
                if (cmd_valid) begin
                    if (cmd_op == OP_CLEAR) begin
                        state_d    = S_IDLE;
                        reason_d   = R_NONE;
                        inst_cnt_d = '0;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d      = S_IDLE;
                reason_d     = R_NONE;
                steps_left_d = '0;
            end
        endcase
    end

    // State registers. Commands arriving during rst are simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            reason_q     <= R_NONE;
            inst_cnt_q   <= '0;
            steps_left_q <= '0;
            cmd_err_q    <= 1'b0;
            skip_bp_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            reason_q     <= reason_d;
            inst_cnt_q   <= inst_cnt_d;
            steps_left_q <= steps_left_d;
            cmd_err_q    <= cmd_err_d;
            skip_bp_q    <= skip_bp_d;
        end
    end

    assign state       = state_q;
    assign stop_reason = reason_q;
    assign inst_cnt    = inst_cnt_q;
    assign steps_left  = steps_left_q;
    assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_run_ctrl
//
// Directed bench for cpu_run_ctrl. A minimal core stand-in advances the fetch
// PC by 4 on every enabled cycle. Its program is addi everywhere, with the halt
// instruction at PC 0x10. Inputs change on the falling edge and outputs are
// sampled there too, away from the rising edge.
// -----------------------------------------------------------------------------
module tb_cpu_run_ctrl;

    localparam logic [31:0] HALT = 32'h8000_0000;
    localparam logic [31:0] ADDI = 32'h0010_0093;

    localparam logic [1:0] RUN   = 2'b00;
    localparam logic [1:0] STEP  = 2'b01;
    localparam logic [1:0] STOP  = 2'b10;
    localparam logic [1:0] CLEAR = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_arg;
    logic        cmd_err;
    logic        bp_en;
    logic [31:0] bp_pc;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_inst;
    logic        global_en;
    logic [2:0]  state;
    logic [2:0]  stop_reason;
    logic [31:0] inst_cnt;
    logic [15:0] steps_left;

    int n_tests = 0;
    int n_fail  = 0;
    int en_total = 0;
    int en_base;

    cpu_run_ctrl #(
        .HALT_INST (HALT),
        .STEP_W    (16),
        .CNT_W     (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .cmd_arg     (cmd_arg),
        .cmd_err     (cmd_err),
        .bp_en       (bp_en),
        .bp_pc       (bp_pc),
        .fetch_pc    (fetch_pc),
        .fetch_inst  (fetch_inst),
        .global_en   (global_en),
        .state       (state),
        .stop_reason (stop_reason),
        .inst_cnt    (inst_cnt),
        .steps_left  (steps_left)
    );

    always #5 clk = ~clk;

    // Core stand-in: PC restarts on rst and advances when enabled.
    always @(posedge clk) begin
        if (rst) fetch_pc <= 32'h0;
        else if (global_en) fetch_pc <= fetch_pc + 32'd4;
        if (global_en) en_total <= en_total + 1;
    end

    assign fetch_inst = (fetch_pc == 32'h10) ? HALT : ADDI;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: strobe one command for one cycle. Returns at the
    // next falling edge, where the registered result is visible.
    task automatic issue(input logic [1:0] op, input logic [15:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Bounded wait for a state; an expired bound shows up as a failed check.
    task automatic wait_state(input string tag, input logic [2:0] exp, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (state == exp) break;
            @(negedge clk);
            #1;
        end
        chk(tag, {29'd0, state}, {29'd0, exp});
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = RUN;
        cmd_arg   = 16'd0;
        bp_en     = 1'b0;
        bp_pc     = 32'h0;

        // Reset, with a RUN strobed during reset that must be dropped.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = RUN;
        #1;
        chk("rst_gen", {31'd0, global_en}, 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst       = 1'b0;
        #1;
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_reason", {29'd0, stop_reason}, 32'd0);
        chk("rst_cnt", inst_cnt, 32'd0);
        chk("rst_steps", {16'd0, steps_left}, 32'd0);
        chk("rst_err", {31'd0, cmd_err}, 32'd0);
        @(negedge clk);
        #1;
        chk("rst_cmd_dropped", {29'd0, state}, 32'd0);

        // STOP in IDLE is illegal.
        issue(STOP, 16'd0);
        chk("idle_stop_err", {31'd0, cmd_err}, 32'd1);
        chk("idle_stop_state", {29'd0, state}, 32'd0);

        // RUN to halt: PCs 0,4,8,C then halt at 0x10 -> 5 enabled cycles.
        en_base = en_total;
        issue(RUN, 16'd0);
        chk("run_state", {29'd0, state}, 32'd1);
        chk("run_gen_first", {31'd0, global_en}, 32'd1);
        wait_state("run_halted", 3'd4, 40);
        chk("run_en_cycles", en_total - en_base, 32'd5);
        chk("run_reason", {29'd0, stop_reason}, 32'd4);
        chk("run_cnt", inst_cnt, 32'd5);
        chk("run_gen_off", {31'd0, global_en}, 32'd0);

        // HALTED: RUN is illegal, CLEAR returns to IDLE.
        issue(RUN, 16'd0);
        chk("halt_run_err", {31'd0, cmd_err}, 32'd1);
        chk("halt_run_state", {29'd0, state}, 32'd4);
        @(negedge clk);
        #1;
        chk("err_one_cycle", {31'd0, cmd_err}, 32'd0);
        issue(CLEAR, 16'd0);
        chk("clear_state", {29'd0, state}, 32'd0);
        chk("clear_cnt", inst_cnt, 32'd0);
        chk("clear_reason", {29'd0, stop_reason}, 32'd0);
        chk("clear_err", {31'd0, cmd_err}, 32'd0);

        // STEP 3 then STEP 0 (treated as 1).
        do_reset();
        en_base = en_total;
        issue(STEP, 16'd3);
        chk("step3_state", {29'd0, state}, 32'd2);
        chk("step3_left", {16'd0, steps_left}, 32'd3);
        wait_state("step3_paused", 3'd3, 20);
        chk("step3_en_cycles", en_total - en_base, 32'd3);
        chk("step3_reason", {29'd0, stop_reason}, 32'd2);
        chk("step3_cnt", inst_cnt, 32'd3);
        chk("step3_left_done", {16'd0, steps_left}, 32'd0);
        chk("step3_pc", fetch_pc, 32'hC);
        en_base = en_total;
        issue(STEP, 16'd0);
        chk("step0_left", {16'd0, steps_left}, 32'd1);
        wait_state("step0_paused", 3'd3, 20);
        chk("step0_en_cycles", en_total - en_base, 32'd1);
        chk("step0_cnt", inst_cnt, 32'd4);
        chk("step0_reason", {29'd0, stop_reason}, 32'd2);

        // Breakpoint at 0x8: pause before it, then resume through it to halt.
        do_reset();
        bp_en = 1'b1;
        bp_pc = 32'h8;
        issue(RUN, 16'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("bp_pc_reached", fetch_pc, 32'h8);
        chk("bp_gen_gated", {31'd0, global_en}, 32'd0);
        @(negedge clk);
        #1;
        chk("bp_state", {29'd0, state}, 32'd3);
        chk("bp_reason", {29'd0, stop_reason}, 32'd3);
        chk("bp_cnt", inst_cnt, 32'd2);
        issue(RUN, 16'd0);
        chk("bp_resume_gen", {31'd0, global_en}, 32'd1);
        wait_state("bp_resume_halt", 3'd4, 40);
        chk("bp_resume_cnt", inst_cnt, 32'd5);
        chk("bp_resume_reason", {29'd0, stop_reason}, 32'd4);

        // Breakpoint on the halt PC wins over the halt.
        do_reset();
        bp_pc = 32'h10;
        issue(RUN, 16'd0);
        wait_state("bphalt_paused", 3'd3, 40);
        chk("bphalt_reason", {29'd0, stop_reason}, 32'd3);
        chk("bphalt_cnt", inst_cnt, 32'd4);
        issue(RUN, 16'd0);
        wait_state("bphalt_resume", 3'd4, 40);
        chk("bphalt_resume_cnt", inst_cnt, 32'd5);
        bp_en = 1'b0;

        // STOP 4 cycles into a RUN (arrives while fetching the halt: STOP wins).
        do_reset();
        issue(RUN, 16'd0);
        repeat (4) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = STOP;
        #1;
        chk("stop_gen_gated", {31'd0, global_en}, 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("stop_state", {29'd0, state}, 32'd3);
        chk("stop_reason", {29'd0, stop_reason}, 32'd1);
        chk("stop_cnt", inst_cnt, 32'd4);
        chk("stop_err_none", {31'd0, cmd_err}, 32'd0);
        issue(STOP, 16'd0);
        chk("stop2_err", {31'd0, cmd_err}, 32'd1);
        chk("stop2_state", {29'd0, state}, 32'd3);
        chk("stop2_reason", {29'd0, stop_reason}, 32'd1);

        // CLEAR while running is illegal and does not stop the core.
        do_reset();
        issue(RUN, 16'd0);
        issue(CLEAR, 16'd0);
        chk("run_clear_err", {31'd0, cmd_err}, 32'd1);
        chk("run_clear_state", {29'd0, state}, 32'd1);
        wait_state("run_clear_halt", 3'd4, 40);

        // rst in the middle of STEP 8 once 5 steps remain.
        do_reset();
        issue(STEP, 16'd8);
        repeat (3) @(negedge clk);
        #1;
        chk("mid_left", {16'd0, steps_left}, 32'd5);
        rst = 1'b1;
        #1;
        chk("mid_rst_gen", {31'd0, global_en}, 32'd0);
        @(negedge clk);
        #1;
        chk("mid_rst_state", {29'd0, state}, 32'd0);
        chk("mid_rst_left", {16'd0, steps_left}, 32'd0);
        chk("mid_rst_cnt", inst_cnt, 32'd0);
        chk("mid_rst_gen2", {31'd0, global_en}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
